// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker
//   Exhaustively sweeps every {a,b} operand pair of width WIDTH through a
//   two-stage pipeline and counts vectors where the two sides of a De Morgan
//   identity disagree.
//   mode 0 : ~(a&b) vs ~a|~b
//   mode 1 : ~(a|b) vs ~a&~b
//
// Parameters
//   WIDTH      operand width (1..8). One sweep covers N = 2^(2*WIDTH) vectors.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset, wins over start
//   start      one-cycle sweep request, honoured only in IDLE/DONE
//   mode       identity select, latched at start
//   inject     (only with DEMORGAN_FAULT_INJECT_EN) flips rhs bit 0 at stage-2 capture
//   busy       high in RUN/DRAIN
//   done       high in DONE
//   pass       high in DONE when no mismatch was seen
//   err_count  mismatch count of the current/last sweep (holds up to N)
//   cur_a/b    stage-1 operands
//   lhs/rhs    stage-2 registered results
//
// Optional feature macro: DEMORGAN_FAULT_INJECT_EN
module demorgan_sweep_checker #(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
`ifdef DEMORGAN_FAULT_INJECT_EN
  input  logic               inject,
`endif
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   cur_a,
  output logic [WIDTH-1:0]   cur_b,
  output logic [WIDTH-1:0]   lhs,
  output logic [WIDTH-1:0]   rhs
);

  localparam int VW = 2 * WIDTH;
  localparam int N  = 1 << VW;
  localparam logic [VW-1:0] LAST = VW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [VW-1:0]    vec_cnt_q;
  logic [VW:0]      err_q;
  logic             mode_q;
  logic             vld_s1_q;   // stage-1 holds a real vector (not a bubble)
  logic             drain_q;    // second DRAIN cycle marker
  logic [WIDTH-1:0] cur_a_q, cur_b_q, lhs_q, rhs_q;
  logic [WIDTH-1:0] lhs_d, rhs_d;
  logic             accept;

  // start is only honoured outside a sweep
  assign accept = start && (state_q == IDLE || state_q == DONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (vec_cnt_q == LAST) state_d = DRAIN;
      DRAIN:      if (drain_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE);
    pass = done && (err_q == '0);
  end

  // stage-2 evaluation from stage-1 operands under the latched mode
  always_comb begin
    if (mode_q) begin
      lhs_d = ~(cur_a_q | cur_b_q);
      rhs_d = ~cur_a_q & ~cur_b_q;
    end else begin
      lhs_d = ~(cur_a_q & cur_b_q);
      rhs_d = ~cur_a_q | ~cur_b_q;
    end
`ifdef DEMORGAN_FAULT_INJECT_EN
    rhs_d[0] = rhs_d[0] ^ inject;
`endif
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt_q <= '0;
      err_q     <= '0;
      mode_q    <= 1'b0;
      vld_s1_q  <= 1'b0;
      drain_q   <= 1'b0;
      cur_a_q   <= '0;
      cur_b_q   <= '0;
      lhs_q     <= '0;
      rhs_q     <= '0;
    end else begin
      vld_s1_q <= (state_q == RUN);
      drain_q  <= (state_q == DRAIN) ? ~drain_q : 1'b0;
      if (accept) begin
        mode_q    <= mode;
        vec_cnt_q <= '0;
        err_q     <= '0;
      end
      if (state_q == RUN) begin
        {cur_a_q, cur_b_q} <= vec_cnt_q;   // b in the low bits
        vec_cnt_q          <= vec_cnt_q + 1'b1;
      end
      // vld_s1_q is never set in IDLE/DONE, so this never collides with the clear above
      if (vld_s1_q) begin
        lhs_q <= lhs_d;
        rhs_q <= rhs_d;
        if (lhs_d != rhs_d) err_q <= err_q + 1'b1;
      end
    end
  end

  assign err_count = err_q;
  assign cur_a     = cur_a_q;
  assign cur_b     = cur_b_q;
  assign lhs       = lhs_q;
  assign rhs       = rhs_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for demorgan_sweep_checker: a WIDTH=1 and a WIDTH=2 instance,
// edge-by-edge table for one sweep, directed corner sequences and a
// randomized run checked against a sweep-timeline model.
module tb_demorgan_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, st1, md1, st2, md2;
`ifdef DEMORGAN_FAULT_INJECT_EN
  logic inj1, inj2;
`endif
  logic       b1, d1, p1, b2, d2, p2;
  logic [2:0] e1;
  logic [4:0] e2;
  logic       a1, bb1, l1, r1;
  logic [1:0] a2, bb2, l2, r2;

  demorgan_sweep_checker #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .mode(md1),
`ifdef DEMORGAN_FAULT_INJECT_EN
    .inject(inj1),
`endif
    .busy(b1), .done(d1), .pass(p1), .err_count(e1),
    .cur_a(a1), .cur_b(bb1), .lhs(l1), .rhs(r1));

  demorgan_sweep_checker #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .mode(md2),
`ifdef DEMORGAN_FAULT_INJECT_EN
    .inject(inj2),
`endif
    .busy(b2), .done(d2), .pass(p2), .err_count(e2),
    .cur_a(a2), .cur_b(bb2), .lhs(l2), .rhs(r2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one rising edge, then settle to the falling edge for sampling
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // WIDTH=1, mode=1 sweep observed after each edge from the start edge on
  typedef struct {
    logic       busy, done, pass;
    logic [1:0] ab;
    logic       lhs, rhs;
    logic [2:0] err;
  } vec_t;
  vec_t tbl[7];

  // sweep-timeline model for the WIDTH=2 instance
  localparam int N2 = 16;
  bit         m_act;
  int         m_age;
  bit         m_mode;
  logic [3:0] m_cur;
  logic [1:0] m_lhs, m_rhs;

  task automatic model_step(input logic r, input logic s, input logic m);
    int v;
    logic [1:0] a, b;
    if (r) begin
      m_act = 0; m_age = 0; m_cur = '0; m_lhs = '0; m_rhs = '0;
    end else if (s && !(m_act && m_age < N2 + 2)) begin
      m_act = 1; m_age = 0; m_mode = m;
    end else if (m_act) begin
      m_age++;
      if (m_age >= 1 && m_age <= N2) m_cur = 4'(m_age - 1);
      if (m_age >= 2 && m_age <= N2 + 1) begin
        v = m_age - 2;
        a = 2'(v / 4);
        b = 2'(v % 4);
        if (m_mode) begin m_lhs = 2'(3 - (a | b)); m_rhs = ~a & ~b; end
        else        begin m_lhs = 2'(3 - (a & b)); m_rhs = ~a | ~b; end
      end
    end
  endtask

  function automatic logic [31:0] obs2();
    return 32'({b2, d2, p2, e2, a2, bb2, l2, r2});
  endfunction

  function automatic logic [31:0] exp2();
    logic eb, ed;
    eb = m_act && (m_age < N2 + 2);
    ed = m_act && (m_age >= N2 + 2);
    return 32'({eb, ed, ed, 5'd0, m_cur, m_lhs, m_rhs});
  endfunction

  initial begin
    int got;
    bit saw;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 3'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 3'd0};

    rst = 1; st1 = 0; md1 = 0; st2 = 0; md2 = 0;
`ifdef DEMORGAN_FAULT_INJECT_EN
    inj1 = 0; inj2 = 0;
`endif
    @(negedge clk);
    tick();
    rst = 0;
    chk("reset_w1", 32'({b1, d1, p1, e1, a1, bb1, l1, r1}), 32'd0);
    chk("reset_w2", obs2(), 32'd0);

    // WIDTH=1 mode=1 sweep, table-driven
    st1 = 1; md1 = 1;
    tick();
    st1 = 0; md1 = 0;   // mode change mid-sweep must not matter
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk($sformatf("w1_tbl_e%0d", i), 32'({b1, d1, p1, a1, bb1, l1, r1, e1}),
          32'({tbl[i].busy, tbl[i].done, tbl[i].pass, tbl[i].ab, tbl[i].lhs, tbl[i].rhs, tbl[i].err}));
    end

    // start during busy ignored; done still at edge 6
    st1 = 1; md1 = 1;
    tick();            // e0 (from DONE)
    st1 = 0;
    tick(); tick();    // e1, e2
    st1 = 1;
    tick();            // e3, ignored
    st1 = 0;
    tick(); tick();    // e4, e5
    chk("w1_busy_e5", 32'({b1, d1}), 32'b10);
    tick();            // e6
    chk("w1_done_e6", 32'({b1, d1, p1, e1}), 32'({3'b011, 3'd0}));
    // restart from DONE
    st1 = 1;
    tick();
    st1 = 0;
    chk("w1_restart", 32'({b1, d1, p1, e1}), 32'({3'b100, 3'd0}));
    for (int i = 0; i < 6; i++) tick();
    chk("w1_restart_done", 32'({b1, d1, p1, e1}), 32'({3'b011, 3'd0}));

    // WIDTH=2 mode=0: done edge counted, bounded
    st2 = 1; md2 = 0;
    tick();
    st2 = 0;
    got = -1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (d2 && got < 0) got = e;
    end
    chk("w2_done_edge", 32'(got), 32'd18);
    chk("w2_pass", 32'({p2, e2}), 32'({1'b1, 5'd0}));

    // reset at edge 3 of a WIDTH=2 sweep
    st2 = 1;
    tick();
    st2 = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("w2_rst_mid", obs2(), 32'd0);
    saw = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (d2 || b2) saw = 1;
    end
    chk("w2_rst_no_done", 32'(saw), 32'd0);

`ifdef DEMORGAN_FAULT_INJECT_EN
    inj2 = 1;
    st2 = 1;
    tick();
    st2 = 0;
    for (int e = 1; e <= 18; e++) tick();
    chk("w2_inj_all", 32'({d2, p2, e2}), 32'({2'b10, 5'd16}));
    inj2 = 0;
    st2 = 1;
    tick();
    st2 = 0;
    for (int e = 1; e <= 18; e++) begin
      inj2 = (e >= 2 && e <= 4);   // stage-2 capture edges of vectors 0..2
      tick();
    end
    inj2 = 0;
    chk("w2_inj_three", 32'({d2, p2, e2}), 32'({2'b10, 5'd3}));
`endif

    // randomized run vs model
    rst = 1;
    tick();
    rst = 0;
    model_step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      logic r, s, m;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 5) == 0);
      m = 1'($urandom);
      rst = r; st2 = s; md2 = m;
      tick();
      model_step(r, s, m);
      chk($sformatf("w2_rand_%0d", i), obs2(), exp2());
    end
    rst = 0; st2 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
